// File: rtl/sar_scan_ctrl.sv
// sar_scan_ctrl: round-robin scan controller in front of one shared SAR ADC core.
// A grant selects the analog mux channel. The controller then waits for the mux to
// settle, pulses the SAR start and waits for end-of-conversion or a timeout. It returns
// the result tagged with its channel, together with a one-hot acknowledge.
module sar_scan_ctrl #(
    parameter int Width         = 6,
    parameter int Channels      = 4,
    parameter int SettleCycles  = 2,
    parameter int TimeoutCycles = 16,
    localparam int CW = (Channels > 1) ? $clog2(Channels) : 1
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                enable_i,
    input  logic [Channels-1:0] req_i,
    output logic [Channels-1:0] ack_o,
    output logic                valid_o,
    output logic                err_o,
    output logic [Width-1:0]    result_o,
    output logic [CW-1:0]       result_ch_o,
    output logic [CW-1:0]       chsel_o,
    output logic                busy_o,
    output logic                sar_start_o,
    input  logic                sar_eoc_i,
    input  logic [Width-1:0]    sar_result_i
);

    localparam int SW = (SettleCycles > 0) ? $clog2(SettleCycles + 1) : 1;
    localparam int TW = (TimeoutCycles > 1) ? $clog2(TimeoutCycles) : 1;
    localparam logic [TW-1:0] TMAX = TW'(TimeoutCycles - 1);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SETTLE  = 3'd1,
        ST_START   = 3'd2,
        ST_CONVERT = 3'd3,
        ST_DONE    = 3'd4
    } state_t;

    state_t                state_r;
    state_t                state_nxt_s;
    logic [CW-1:0]         last_grant_r;
    logic [CW-1:0]         grant_s;
    logic [CW-1:0]         idx_s;
    logic                  grant_hit_s;
    logic [SW-1:0]         cnt_r;
    logic [TW-1:0]         tcnt_r;
    logic                  timeout_s;
    logic [Channels-1:0]   ack_nxt_s;
    logic                  valid_nxt_s;
    logic                  err_nxt_s;
    logic                  start_nxt_s;
    logic                  busy_nxt_s;

    // A timeout fires on the last allowed CONVERT cycle without an eoc.
    assign timeout_s = (state_r == ST_CONVERT) && !sar_eoc_i && (tcnt_r == TMAX);

    // Round-robin pick: the nearest requester after last_grant wins. The scan runs
    // from farthest to nearest, so the last hit is the nearest one.
    always_comb begin
        grant_s     = {CW{1'b0}};
        grant_hit_s = 1'b0;
        idx_s       = {CW{1'b0}};
        for (int i = Channels; i >= 1; i--) begin
            idx_s = CW'((int'(last_grant_r) + i) % Channels);
            if (req_i[idx_s]) begin
                grant_s     = idx_s;
                grant_hit_s = 1'b1;
            end else begin
                grant_s     = grant_s;
                grant_hit_s = grant_hit_s;
            end
        end
    end

    // State register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic. SETTLE counts cnt down to zero and then moves to START.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (enable_i && grant_hit_s) begin
                    state_nxt_s = (SettleCycles == 0) ? ST_START : ST_SETTLE;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_SETTLE: begin
                if (cnt_r == {SW{1'b0}}) begin
                    state_nxt_s = ST_START;
                end else begin
                    state_nxt_s = ST_SETTLE;
                end
            end
            ST_START:   state_nxt_s = ST_CONVERT;
            ST_CONVERT: begin
                if (sar_eoc_i || timeout_s) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_CONVERT;
                end
            end
            ST_DONE:    state_nxt_s = ST_IDLE;
            default:    state_nxt_s = ST_IDLE;
        endcase
    end

    // Datapath: grant bookkeeping, settle/timeout counters and result capture.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            last_grant_r <= CW'(Channels - 1);
            chsel_o      <= {CW{1'b0}};
            cnt_r        <= {SW{1'b0}};
            tcnt_r       <= {TW{1'b0}};
            result_o     <= {Width{1'b0}};
            result_ch_o  <= {CW{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (state_nxt_s != ST_IDLE) begin
                        chsel_o      <= grant_s;
                        last_grant_r <= grant_s;
                        cnt_r        <= SW'(SettleCycles);
                    end
                end
                ST_SETTLE: begin
                    if (cnt_r != {SW{1'b0}}) begin
                        cnt_r <= cnt_r - SW'(1'b1);
                    end
                end
                ST_START: tcnt_r <= {TW{1'b0}};
                ST_CONVERT: begin
                    if (sar_eoc_i) begin
                        result_o    <= sar_result_i;
                        result_ch_o <= chsel_o;
                    end else if (timeout_s) begin
                        result_o    <= {Width{1'b0}};
                        result_ch_o <= chsel_o;
                    end else begin
                        tcnt_r <= tcnt_r + TW'(1'b1);
                    end
                end
                default: begin
                    cnt_r <= cnt_r;
                end
            endcase
        end
    end

    // Output decode from the next state, so the registered outputs line up with the state.
    always_comb begin
        ack_nxt_s   = {Channels{1'b0}};
        valid_nxt_s = (state_nxt_s == ST_DONE);
        err_nxt_s   = timeout_s;
        start_nxt_s = (state_nxt_s == ST_START);
        busy_nxt_s  = (state_nxt_s != ST_IDLE);
        if (state_nxt_s == ST_DONE) begin
            ack_nxt_s[chsel_o] = 1'b1;
        end else begin
            ack_nxt_s = {Channels{1'b0}};
        end
    end

    // Output registers. Reset clears them at once, so no ack or start leaks out.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ack_o       <= {Channels{1'b0}};
            valid_o     <= 1'b0;
            err_o       <= 1'b0;
            sar_start_o <= 1'b0;
            busy_o      <= 1'b0;
        end else begin
            ack_o       <= ack_nxt_s;
            valid_o     <= valid_nxt_s;
            err_o       <= err_nxt_s;
            sar_start_o <= start_nxt_s;
            busy_o      <= busy_nxt_s;
        end
    end

endmodule

// File: tb/tb_sar_scan_ctrl.sv
// tb_sar_scan_ctrl: directed bench for sar_scan_ctrl (Width 6, 4 channels, settle 2, timeout 16).
module tb_sar_scan_ctrl;

    logic       clk;
    logic       rst;
    logic       enable;
    logic [3:0] req;
    logic [3:0] ack;
    logic       valid;
    logic       err;
    logic [5:0] result;
    logic [1:0] result_ch;
    logic [1:0] chsel;
    logic       busy;
    logic       sar_start;
    logic       sar_eoc;
    logic [5:0] sar_result;

    int n_total;
    int n_pass;
    int n_cyc;
    int n_starts;

    sar_scan_ctrl #(
        .Width(6), .Channels(4), .SettleCycles(2), .TimeoutCycles(16)
    ) dut (
        .clk_i(clk), .rst_i(rst), .enable_i(enable), .req_i(req),
        .ack_o(ack), .valid_o(valid), .err_o(err), .result_o(result),
        .result_ch_o(result_ch), .chsel_o(chsel), .busy_o(busy),
        .sar_start_o(sar_start), .sar_eoc_i(sar_eoc), .sar_result_i(sar_result)
    );

    // Free-running 10-unit clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    // Advance one clock; land 1 unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Step until sar_start is seen (bounded); n returns the steps taken.
    task automatic wait_start(input string tag, output int n);
        n = 0;
        while (sar_start !== 1'b1 && n < 60) begin
            tick();
            n++;
        end
        check({tag, "_start_seen"}, 32'(sar_start), 32'd1);
    endtask

    // Called in the START cycle: eoc follows dly cycles later, and valid must follow one edge after.
    task automatic do_conv(input string tag, input int dly, input logic [5:0] data, input int ch);
        repeat (dly) tick();
        sar_eoc    = 1'b1;
        sar_result = data;
        tick();
        sar_eoc    = 1'b0;
        sar_result = 6'h00;
        check({tag, "_valid"}, 32'(valid), 32'd1);
        check({tag, "_ack"}, 32'(ack), 32'(4'b0001 << ch));
        check({tag, "_err"}, 32'(err), 32'd0);
        check({tag, "_result"}, 32'(result), 32'(data));
        check({tag, "_result_ch"}, 32'(result_ch), 32'(ch));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        tick();
    endtask

    initial begin
        n_total = 0; n_pass = 0;
        rst = 1'b1; enable = 1'b1; req = 4'b0000; sar_eoc = 1'b0; sar_result = 6'h00;
        repeat (3) tick();
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_outs", 32'({ack, valid, err, sar_start}), 32'd0);
        check("rst_data", 32'({result, result_ch, chsel}), 32'd0);
        rst = 1'b0;
        tick();

        // T1: single request on ch2; start exactly on the 3rd edge after the grant edge.
        req = 4'b0100;
        tick();
        check("t1_chsel", 32'(chsel), 32'd2);
        check("t1_busy", 32'(busy), 32'd1);
        check("t1_start_e0", 32'(sar_start), 32'd0);
        tick();
        check("t1_start_e1", 32'(sar_start), 32'd0);
        tick();
        check("t1_start_e2", 32'(sar_start), 32'd0);
        tick();
        check("t1_start_e3", 32'(sar_start), 32'd1);
        tick();
        check("t1_start_e4", 32'(sar_start), 32'd0);
        sar_eoc = 1'b1; sar_result = 6'h2A;
        tick();
        sar_eoc = 1'b0; sar_result = 6'h00;
        req = 4'b0000;
        check("t1_valid", 32'(valid), 32'd1);
        check("t1_ack", 32'(ack), 32'h4);
        check("t1_result", 32'(result), 32'h2A);
        check("t1_result_ch", 32'(result_ch), 32'd2);
        check("t1_err", 32'(err), 32'd0);
        tick();
        check("t1_valid_pulse", 32'(valid), 32'd0);
        check("t1_ack_pulse", 32'(ack), 32'd0);

        // T2: all four requesting from reset; round-robin order 0,1,2,3,0.
        do_reset();
        req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            wait_start("t2", n_cyc);
            check("t2_chsel", 32'(chsel), 32'(k % 4));
            do_conv("t2", 4, 6'(6'h30 + k), k % 4);
        end

        // T3: ch1 with no eoc at all; timeout after 16 CONVERT cycles.
        req = 4'b0010;
        wait_start("t3", n_cyc);
        check("t3_chsel", 32'(chsel), 32'd1);
        n_cyc = 0;
        while (valid !== 1'b1 && n_cyc < 40) begin
            tick();
            n_cyc++;
        end
        req = 4'b0000;
        check("t3_latency", 32'(n_cyc), 32'd17);
        check("t3_err", 32'(err), 32'd1);
        check("t3_result", 32'(result), 32'd0);
        check("t3_ack", 32'(ack), 32'h2);
        check("t3_result_ch", 32'(result_ch), 32'd1);
        tick();
        check("t3_err_pulse", 32'(err), 32'd0);

        // T4: reset in the middle of CONVERT; everything clears before the next edge.
        req = 4'b0100;
        wait_start("t4", n_cyc);
        tick();
        tick();
        check("t4_busy_pre", 32'(busy), 32'd1);
        rst = 1'b1;
        #1;
        check("t4_busy", 32'(busy), 32'd0);
        check("t4_outs", 32'({ack, valid, err, sar_start}), 32'd0);
        check("t4_data", 32'({result, result_ch, chsel}), 32'd0);
        req = 4'b0000;
        tick();
        rst = 1'b0;
        n_cyc = 0;
        for (int k = 0; k < 4; k++) begin
            tick();
            if (valid === 1'b1) n_cyc++;
        end
        check("t4_no_valid", 32'(n_cyc), 32'd0);
        req = 4'b1000;
        wait_start("t4b", n_cyc);
        check("t4_chsel", 32'(chsel), 32'd3);
        do_conv("t4b", 2, 6'h07, 3);
        req = 4'b0000;

        // T5: disabled controller ignores requests and stray eoc, then grants ch0.
        tick();
        enable = 1'b0;
        req = 4'b0001;
        n_starts = 0;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (sar_start === 1'b1) n_starts++;
        end
        check("t5_no_start", 32'(n_starts), 32'd0);
        check("t5_idle", 32'(busy), 32'd0);
        sar_eoc = 1'b1; sar_result = 6'h3F;
        tick();
        sar_eoc = 1'b0; sar_result = 6'h00;
        tick();
        check("t5_no_valid", 32'(valid), 32'd0);
        check("t5_result_kept", 32'(result), 32'h07);
        enable = 1'b1;
        wait_start("t5", n_cyc);
        check("t5_chsel", 32'(chsel), 32'd0);
        do_conv("t5", 3, 6'h0C, 0);
        req = 4'b0000;
        tick();

        // T6: request dropped mid-conversion is still completed and acked.
        req = 4'b0001;
        wait_start("t6", n_cyc);
        check("t6_chsel", 32'(chsel), 32'd0);
        tick();
        req = 4'b0000;
        do_conv("t6", 2, 6'h15, 0);
        n_starts = 0;
        for (int k = 0; k < 6; k++) begin
            tick();
            if (sar_start === 1'b1) n_starts++;
        end
        check("t6_no_restart", 32'(n_starts), 32'd0);
        check("t6_idle", 32'(busy), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
